// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format definitions for the encoder and the decoder-side extender.
package imm_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_RANGE = 2'b01,
    ERR_ALIGN = 2'b10,
    ERR_FMT   = 2'b11
  } err_kind_t;

  localparam logic [31:0] MASK_I  = 32'hFFF0_0000;
  localparam logic [31:0] MASK_SB = 32'hFE00_0F80;
  localparam logic [31:0] MASK_JU = 32'hFFFF_F000;

  typedef struct packed {
    logic [2:0]  immsrc;
    logic [31:0] imm;
    logic [31:0] base;
  } imm_req_t;

  // True when v[31:msb] are all copies of v[msb], i.e. v fits in msb+1 signed bits.
  function automatic logic sext_ok(input logic [31:0] v, input int unsigned msb);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i > msb && v[i] != v[msb]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request and result handshake bundle for imm_encoder.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_immsrc;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [1:0]  out_err_kind;

  modport master (
    output in_valid, in_immsrc, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_instr, out_err, out_err_kind
  );

  modport slave (
    input  in_valid, in_immsrc, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_instr, out_err, out_err_kind
  );
endinterface

// File: rtl/imm_encoder_pack.sv
// Combinational immediate scatter into a base instruction word, with range/alignment checks.
module imm_pack
  import imm_pkg::*;
(
  input  logic [2:0]  immsrc_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] base_i,
  output logic [31:0] instr_o,
  output logic        err_o,
  output err_kind_t   err_kind_o
);

  logic [31:0] field;
  logic [31:0] mask;
  err_kind_t   kind;

  always_comb begin
    field = '0;
    mask  = '0;
    kind  = ERR_NONE;
    case (immsrc_i)
      IMM_I: begin
        field = {imm_i[11:0], 20'b0};
        mask  = MASK_I;
        if (!sext_ok(imm_i, 11)) kind = ERR_RANGE;
      end
      IMM_S: begin
        field = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
        mask  = MASK_SB;
        if (!sext_ok(imm_i, 11)) kind = ERR_RANGE;
      end
      IMM_B: begin
        field = {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
        mask  = MASK_SB;
        if (imm_i[0])                kind = ERR_ALIGN;
        else if (!sext_ok(imm_i, 12)) kind = ERR_RANGE;
      end
      IMM_J: begin
        field = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0};
        mask  = MASK_JU;
        if (imm_i[0])                kind = ERR_ALIGN;
        else if (!sext_ok(imm_i, 20)) kind = ERR_RANGE;
      end
      IMM_U: begin
        field = {imm_i[31:12], 12'b0};
        mask  = MASK_JU;
        if (|imm_i[11:0]) kind = ERR_ALIGN;
      end
      // Illegal formats leave mask at zero so the base word passes through untouched.
      default: kind = ERR_FMT;
    endcase
  end

  assign instr_o    = (base_i & ~mask) | field;
  assign err_kind_o = kind;
  assign err_o      = (kind != ERR_NONE);

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready pipeline around imm_pack, with a saturating delivered-error counter.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  imm_encoder_if.slave         bus,
  output logic [ERR_CNT_W-1:0] err_count
);

  imm_req_t              s1_q;
  logic                  s1_valid_q;
  logic                  s2_valid_q;
  logic [31:0]           s2_instr_q;
  logic                  s2_err_q;
  err_kind_t             s2_kind_q;
  logic [ERR_CNT_W-1:0]  err_cnt_q;
  logic [ERR_CNT_W-1:0]  err_cnt_d;

  logic [31:0] pk_instr;
  logic        pk_err;
  err_kind_t   pk_kind;

  logic s2_adv;
  logic s1_adv;
  logic in_fire;
  logic out_fire;

  assign s2_adv   = !s2_valid_q || bus.out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_fire  = bus.in_valid && s1_adv;
  assign out_fire = s2_valid_q && bus.out_ready;

  imm_pack u_pack (
    .immsrc_i   (s1_q.immsrc),
    .imm_i      (s1_q.imm),
    .base_i     (s1_q.base),
    .instr_o    (pk_instr),
    .err_o      (pk_err),
    .err_kind_o (pk_kind)
  );

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_fire && s2_err_q && err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
      s2_kind_q  <= ERR_NONE;
      err_cnt_q  <= '0;
    end else begin
      if (s1_adv) s1_valid_q <= bus.in_valid;
      if (in_fire) s1_q <= '{immsrc: bus.in_immsrc, imm: bus.in_imm, base: bus.in_base};
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_instr_q <= pk_instr;
          s2_err_q   <= pk_err;
          s2_kind_q  <= pk_kind;
        end
      end
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.in_ready     = s1_adv;
  assign bus.out_valid    = s2_valid_q;
  assign bus.out_instr    = s2_instr_q;
  assign bus.out_err      = s2_err_q;
  assign bus.out_err_kind = s2_kind_q;
  assign err_count        = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized and directed bench for imm_encoder against a bit-position reference model.
module tb_imm_encoder;
  import imm_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  imm_encoder_if bus ();
  imm_encoder_if bus2 ();

  imm_encoder u_dut (.clk(clk), .reset(reset), .bus(bus), .err_count(err_count));
  imm_encoder #(.ERR_CNT_W(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2), .err_count(err_count2));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] instr;
    logic        err;
    logic [1:0]  kind;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   accepted;
  int   model_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Which immediate bit lands at instruction bit p for a format (-1: not an immediate bit).
  function automatic int imm_pos(input logic [2:0] src, input int p);
    int r = -1;
    case (src)
      IMM_I: if (p >= 20) r = p - 20;
      IMM_S: if (p >= 25) r = p - 20; else if (p >= 7 && p <= 11) r = p - 7;
      IMM_B: if (p == 31) r = 12; else if (p >= 25) r = p - 20;
             else if (p >= 8 && p <= 11) r = p - 7; else if (p == 7) r = 11;
      IMM_J: if (p == 31) r = 20; else if (p >= 21) r = p - 20;
             else if (p == 20) r = 11; else if (p >= 12) r = p;
      IMM_U: if (p >= 12) r = p;
      default: r = -1;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_mask(input logic [2:0] src);
    logic [31:0] m = '0;
    for (int p = 0; p < 32; p++) if (imm_pos(src, p) >= 0) m[p] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] ref_ext(input logic [2:0] src, input logic [31:0] ins);
    case (src)
      IMM_I:   return {{20{ins[31]}}, ins[31:20]};
      IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return {ins[31:12], 12'b0};
    endcase
  endfunction

  function automatic exp_t model(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] base);
    exp_t   e;
    longint v = longint'($signed(imm));
    int     k;
    e.src = src; e.imm = imm; e.base = base; e.instr = base;
    e.acc_cyc = 0; e.chk_lat = 1'b0;
    for (int p = 0; p < 32; p++) begin
      k = imm_pos(src, p);
      if (k >= 0) e.instr[p] = imm[k];
    end
    if (src > 3'd4) e.kind = 2'b11;
    else if (((src == IMM_B || src == IMM_J) && imm[0]) || (src == IMM_U && imm[11:0] != 0)) e.kind = 2'b10;
    else if (((src == IMM_I || src == IMM_S) && (v < -2048 || v > 2047)) ||
             (src == IMM_B && (v < -4096 || v > 4095)) ||
             (src == IMM_J && (v < -1048576 || v > 1048575))) e.kind = 2'b01;
    else e.kind = 2'b00;
    e.err = (e.kind != 2'b00);
    return e;
  endfunction

  function automatic exp_t mk(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] base,
                              input logic [31:0] instr, input logic [1:0] kind);
    exp_t e;
    e.src = src; e.imm = imm; e.base = base; e.instr = instr; e.kind = kind;
    e.err = (kind != 2'b00); e.acc_cyc = 0; e.chk_lat = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] rand_imm();
    logic [31:0] v = $urandom;
    case ($urandom_range(0, 4))
      0: ;
      1: v = {{20{v[11]}}, v[11:0]};
      2: v = {{19{v[12]}}, v[12:1], 1'b0};
      3: v = {{11{v[20]}}, v[20:1], 1'b0};
      default: v = {v[31:12], 12'b0};
    endcase
    return v;
  endfunction

  task automatic drive(input exp_t e);
    cur = e;
    bus.in_immsrc = e.src;
    bus.in_imm    = e.imm;
    bus.in_base   = e.base;
    bus.in_valid  = 1'b1;
  endtask

  // One cycle: sample handshakes #1 after the negedge, score them, advance to the next negedge.
  task automatic step();
    exp_t e;
    #1;
    accepted = 1'b0;
    if (!reset && bus.out_valid) begin
      if (q.size() == 0) check("spurious_out_valid", 32'(bus.out_valid), 0);
      else if (bus.out_ready) begin
        e = q.pop_front();
        check("instr", bus.out_instr, e.instr);
        check("err", 32'(bus.out_err), 32'(e.err));
        check("kind", 32'(bus.out_err_kind), 32'(e.kind));
        if (e.chk_lat) check("latency", 32'(cyc - e.acc_cyc), 2);
        if (!e.err && !bus.out_err) begin
          check("roundtrip", ref_ext(e.src, bus.out_instr), e.imm);
          check("passthru", bus.out_instr & ~ref_mask(e.src), e.base & ~ref_mask(e.src));
        end
        if (e.err && model_cnt < 255) model_cnt++;
      end else check("stall_instr", bus.out_instr, q[0].instr);
    end
    if (!reset && bus.in_valid && bus.in_ready) begin
      accepted = 1'b1;
      cur.acc_cyc = cyc;
      q.push_back(cur);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input exp_t e);
    bit done = 1'b0;
    drive(e);
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      done = accepted;
    end
    if (!done) check("send_timeout", 32'(done), 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && q.size() != 0; i++) step();
    check("drain_empty", 32'(q.size()), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t bp[3];
    exp_t e;
    int   idx;
    int   sent;
    int   guard;
    int   fires2;
    logic [2:0] s;

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_immsrc = '0; bus.in_imm = '0; bus.in_base = '0; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_immsrc = '0; bus2.in_imm = '0; bus2.in_base = '0; bus2.out_ready = 1'b1;
    cur = model(IMM_I, '0, '0);
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_instr", bus.out_instr, 0);
    check("rst_out_err", 32'(bus.out_err), 0);
    check("rst_kind", 32'(bus.out_err_kind), 0);
    check("rst_err_count", 32'(err_count), 0);
    reset = 1'b0;
    @(negedge clk);

    e = mk(IMM_I, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 2'b00);
    e.chk_lat = 1'b1;
    send(e);
    drain(10);

    send(mk(IMM_S, 32'h0000_07FF, 32'h0000_2023, 32'h7E00_2FA3, 2'b00));
    send(mk(IMM_B, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 2'b00));
    send(mk(IMM_U, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 2'b00));
    drain(10);

    send(mk(IMM_I, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 2'b01));
    send(mk(IMM_J, 32'h0000_0003, 32'h0000_006F, 32'h0020_006F, 2'b10));
    send(mk(3'b111, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b11));
    drain(10);
    check("err_count_3", 32'(err_count), 3);

    // Backpressure: two requests fit, the third waits until the consumer drains.
    bp[0] = model(IMM_I, 32'h0000_0123, 32'h0000_0093);
    bp[1] = model(IMM_S, 32'hFFFF_F800, 32'h0000_0023);
    bp[2] = model(IMM_J, 32'h000F_FFFE, 32'h0000_00EF);
    bus.out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 3; i++) begin
      drive(bp[idx]);
      step();
      if (accepted) idx++;
    end
    check("bp_accepts", 32'(idx), 2);
    check("bp_in_ready", 32'(bus.in_ready), 0);
    repeat (2) step();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && idx < 3; i++) begin
      drive(bp[idx]);
      step();
      if (accepted) idx++;
    end
    bus.in_valid = 1'b0;
    check("bp_all_accepted", 32'(idx), 3);
    drain(10);

    // Reset with two entries in flight; neither may ever be delivered.
    bus.out_ready = 1'b0;
    send(model(IMM_I, 32'h0000_0800, 32'h0000_0013));
    send(model(IMM_B, 32'h0000_0001, 32'h0000_0063));
    reset = 1'b1;
    step();
    reset = 1'b0;
    q.delete();
    model_cnt = 0;
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_err_count", 32'(err_count), 0);
    check("midrst_out_instr", bus.out_instr, 0);
    check("midrst_in_ready", 32'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    repeat (5) step();

    sent = 0;
    guard = 0;
    while (sent < 10000 && guard < 60000) begin
      if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
        s = 3'($urandom_range(0, 5));
        if (s == 3'd5) s = 3'($urandom_range(5, 7));
        drive(model(s, rand_imm(), $urandom));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
      if (accepted) begin
        sent++;
        bus.in_valid = 1'b0;
      end
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("random_sent", 32'(sent), 10000);
    drain(20);
    check("err_count_model", 32'(err_count), 32'(model_cnt));

    // Narrow counter saturates at 3 after five errored deliveries.
    fires2 = 0;
    bus2.in_immsrc = 3'b101;
    bus2.in_imm    = 32'h0000_0001;
    bus2.in_base   = 32'h0BAD_F00D;
    for (int i = 0; i < 12; i++) begin
      bus2.in_valid = (i < 5);
      #1;
      if (bus2.out_valid && bus2.out_ready) fires2++;
      @(posedge clk);
      @(negedge clk);
    end
    check("cnt2_delivered", 32'(fires2), 5);
    check("cnt2_saturated", 32'(err_count2), 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the decoder-side immediate extender: takes a 32-bit immediate value, an immediate format (immsrc) and a base instruction word, and scatters the immediate into the format's instruction bit positions.
- Range- and alignment-checks the immediate so that re-extending the output reproduces the input exactly.
- Sits in the instruction-generation / self-test path, between a stimulus or assembler source and instruction memory.
- Two-stage valid/ready pipeline with an error flag and a saturating error counter.

Parameters:
- ERR_CNT_W, 8: width of err_count.

Ports:
- clk  input  1  system clock; single clock domain, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- in_immsrc  input  3  format: 000 I, 001 S, 010 B, 011 J, 100 U; 101–111 illegal.
- in_imm  input  32  immediate value (two's complement; U supplies the full value, low 12 bits expected zero).
- in_base  input  32  instruction word; bits at the format's immediate positions are ignored.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_instr  output  32  encoded instruction.
- out_err  output  1  result carries an error.
- out_err_kind  output  2  00 none, 01 range, 10 misaligned, 11 bad format.
- err_count  output  ERR_CNT_W  errored results delivered, saturating.

Behaviour:
- Reset: s1_valid=0, s2_valid=0, out_valid=0, out_instr=0, out_err=0, out_err_kind=00, err_count=0. Reset mid-operation discards all in-flight entries with no output handshake.
- Pipeline:
  - S1 registers {immsrc, imm, base} on in_valid & in_ready.
  - S2 registers the packed result plus error information computed combinationally from S1.
  - Latency: 2 cycles from the accept edge to out_valid when unstalled. Throughput: 1 per cycle.
- Handshake:
  - s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv.
  - S2 content holds stable while out_valid & !out_ready.
  - Transfers are in order, with no loss and no duplication.
  - in_ready must not depend combinationally on in_valid.
- Immediate mask (bits replaced in base; all other base bits pass through unchanged):
  - I: [31:20]
  - S/B: [31:25], [11:7]
  - J/U: [31:12]
- Packing:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - U: [31:12]=imm[31:12].
- Checks:
  - I/S: range error unless imm[31:11] are all equal.
  - B: range error unless imm[31:12] are all equal; misaligned if imm[0]=1.
  - J: range error unless imm[31:20] are all equal; misaligned if imm[0]=1.
  - U: misaligned if imm[11:0]≠0.
  - Illegal immsrc: out_instr=in_base unchanged, kind 11.
  - Kind priority: bad format > misaligned > range.
  - On range or misaligned error, out_instr is still the truncated pack.
- Round trip: whenever out_err=0, sign/zero-extending out_instr with the same immsrc returns in_imm bit-exact.
- err_count: increments on out_valid & out_ready & out_err; saturates at 2^ERR_CNT_W−1 and never wraps.

Decomposition:
- Shared package imm_pkg:
  - immsrc localparams IMM_I=3'b000, IMM_S, IMM_B, IMM_J, IMM_U; common to this block and the extender.
  - err_kind_t enum (ERR_NONE, ERR_RANGE, ERR_ALIGN, ERR_FMT).
  - Per-format mask constants.
- Sub-module imm_pack: purely combinational; (immsrc, imm, base) → (instr, err, err_kind); instantiated between S1 and S2.
- Pipeline and counter logic stay in imm_encoder.

Test Plan:
- I, imm=0xFFFFFFFF, base=0x00000013 → out_instr=0xFFF00013, err=0, out_valid exactly 2 cycles after accept.
- S, imm=0x000007FF, base=0x00002023 → 0x7E002FA3, err=0. B, imm=0xFFFFFFFC, base=0x00000063 → 0xFE000EE3, err=0. U, imm=0x12345000, base=0x37 → 0x12345037.
- Errors:
  - I, imm=0x00000800 → out_instr=0x80000013, err=1, kind=01.
  - J, imm=0x00000003 → kind=10.
  - immsrc=111, base=0xDEADBEEF → out_instr=0xDEADBEEF, kind=11.
  - err_count=3 after these three transfers.
- Backpressure: hold out_ready=0 and offer 3 back-to-back requests → exactly 2 accepted, then in_ready=0. Release out_ready → all 3 delivered in order with stable data while stalled.
- Reset mid-flight with 2 entries pending → out_valid=0 the next cycle, err_count=0, neither entry ever appears. With ERR_CNT_W=2 and 5 errored transfers → err_count stays at 3.
- Random round trip over 10k requests: whenever err=0, a reference extend of out_instr equals in_imm, and non-mask bits equal in_base.
